// File: rtl/bp_be_prefetch_dispatch_arb.sv
// bp_be_prefetch_dispatch_arb
// Arbitrates the BE dispatch slot between demand packets from the issue path
// and prefetch packets from the prefetch generator. Demand wins unless the
// prefetch has been starved for starve_limit_p cycles. Prefetches are also
// throttled by an outstanding-credit limit and by a holdoff window after flush.
// The output mux has zero latency: outputs are combinational from the inputs
// and the state registers. pkt_width_p is the bp_be_dispatch_pkt_s width for
// the target processor configuration.

module bp_be_prefetch_dispatch_arb_chk #(
  parameter int unsigned cw_p = 3
) (
  input logic            clk_i,
  input logic            reset_i,
  input logic            pf_done_i,
  input logic            demand_yumi_i,
  input logic            pf_yumi_i,
  input logic [cw_p-1:0] outstanding_i
);
  // A completion with no prefetch outstanding is an upstream protocol error.
  always_ff @(posedge clk_i) begin
    if (!reset_i && pf_done_i) begin
      assert (outstanding_i != '0);
    end
  end

  // Only one packet may be consumed per cycle.
  always_ff @(posedge clk_i) begin
    assert (!(demand_yumi_i && pf_yumi_i));
  end
endmodule

module bp_be_prefetch_dispatch_arb #(
  parameter int unsigned pkt_width_p       = 64,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned starve_limit_p    = 16,
  parameter int unsigned holdoff_cycles_p  = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pf_enable_i,
  input  logic                   flush_i,
  input  logic                   demand_v_i,
  input  logic [pkt_width_p-1:0] demand_pkt_i,
  output logic                   demand_yumi_o,
  input  logic                   pf_v_i,
  input  logic [pkt_width_p-1:0] pf_pkt_i,
  output logic                   pf_yumi_o,
  input  logic                   pf_done_i,
  input  logic                   dispatch_ready_and_i,
  output logic                   dispatch_v_o,
  output logic [pkt_width_p-1:0] dispatch_pkt_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] pf_outstanding_o
);

  localparam int unsigned CW = $clog2(max_outstanding_p + 1);
  localparam int unsigned SW = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
  localparam int unsigned HW = (holdoff_cycles_p > 1) ? $clog2(holdoff_cycles_p) : 1;

  localparam logic [CW-1:0] MAX_OUT     = CW'(max_outstanding_p);
  localparam logic [SW-1:0] STARVE_LIM  = SW'(starve_limit_p);
  localparam logic [HW-1:0] HOLDOFF_INI = HW'(holdoff_cycles_p - 1);
  localparam logic          FORCE_EN    = (starve_limit_p != 0);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HOLDOFF = 1'b1
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_outstanding;
  logic [SW-1:0] r_starve;
  logic [HW-1:0] r_holdoff;

  logic w_pf_elig;
  logic w_force;
  logic w_sel_pf;
  logic w_sel_dem;
  logic w_demand_yumi;
  logic w_pf_yumi;
  logic [pkt_width_p-1:0] w_pkt;

  // Eligibility, priority selection and handshake generation.
  always_comb begin
    w_pf_elig = pf_v_i & pf_enable_i & (r_state == RUN)
              & (r_outstanding < MAX_OUT) & ~flush_i;
    w_force   = FORCE_EN & (r_starve == STARVE_LIM) & w_pf_elig;
    if (reset_i) begin
      w_sel_pf  = 1'b0;
      w_sel_dem = 1'b0;
    end else if (w_force || (w_pf_elig && !demand_v_i)) begin
      w_sel_pf  = 1'b1;
      w_sel_dem = 1'b0;
    end else if (demand_v_i) begin
      w_sel_pf  = 1'b0;
      w_sel_dem = 1'b1;
    end else begin
      w_sel_pf  = 1'b0;
      w_sel_dem = 1'b0;
    end
    if (w_sel_pf) begin
      w_pkt = pf_pkt_i;
    end else if (w_sel_dem) begin
      w_pkt = demand_pkt_i;
    end else begin
      w_pkt = '0;
    end
    w_demand_yumi = w_sel_dem & dispatch_ready_and_i & ~flush_i;
    w_pf_yumi     = w_sel_pf & dispatch_ready_and_i & ~flush_i;
  end

  assign dispatch_v_o     = (w_sel_pf | w_sel_dem) & ~flush_i;
  assign dispatch_pkt_o   = w_pkt;
  assign demand_yumi_o    = w_demand_yumi;
  assign pf_yumi_o        = w_pf_yumi;
  assign pf_outstanding_o = r_outstanding;

  // Outstanding-prefetch credit counter; a grant and a completion together cancel.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_outstanding <= '0;
    end else if (w_pf_yumi && !pf_done_i) begin
      r_outstanding <= r_outstanding + CW'(1);
    end else if (pf_done_i && !w_pf_yumi && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - CW'(1);
    end else begin
      r_outstanding <= r_outstanding;
    end
  end

  // Starvation counter: counts cycles an eligible prefetch loses to demand.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_starve <= '0;
    end else if (w_pf_yumi || !pf_v_i || flush_i) begin
      r_starve <= '0;
    end else if (w_pf_elig && demand_v_i && (r_starve < STARVE_LIM)) begin
      r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= r_starve;
    end
  end

  // Flush holdoff FSM: prefetch is blocked for holdoff_cycles_p cycles after a flush.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= RUN;
      r_holdoff <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (flush_i) begin
            r_state   <= HOLDOFF;
            r_holdoff <= HOLDOFF_INI;
          end else begin
            r_state   <= RUN;
            r_holdoff <= r_holdoff;
          end
        end
        HOLDOFF: begin
          if (flush_i) begin
            r_state   <= HOLDOFF;
            r_holdoff <= HOLDOFF_INI;
          end else if (r_holdoff == '0) begin
            r_state   <= RUN;
            r_holdoff <= '0;
          end else begin
            r_state   <= HOLDOFF;
            r_holdoff <= r_holdoff - HW'(1);
          end
        end
        default: begin
          r_state   <= RUN;
          r_holdoff <= '0;
        end
      endcase
    end
  end

  bp_be_prefetch_dispatch_arb_chk #(
    .cw_p(CW)
  ) u_chk (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .pf_done_i     (pf_done_i),
    .demand_yumi_i (w_demand_yumi),
    .pf_yumi_i     (w_pf_yumi),
    .outstanding_i (r_outstanding)
  );

endmodule

// File: tb/tb_bp_be_prefetch_dispatch_arb.sv
// Directed, table-driven bench for bp_be_prefetch_dispatch_arb with default
// limits (4 outstanding, starve limit 16, holdoff 8).
module tb_bp_be_prefetch_dispatch_arb;
  localparam int PW = 16;
  localparam logic [PW-1:0] DPKT = 16'hD00D;
  localparam logic [PW-1:0] PPKT = 16'hAF0F;

  logic          clk;
  logic          reset;
  logic          pf_enable;
  logic          flush;
  logic          demand_v;
  logic [PW-1:0] demand_pkt;
  logic          demand_yumi;
  logic          pf_v;
  logic [PW-1:0] pf_pkt;
  logic          pf_yumi;
  logic          pf_done;
  logic          ready;
  logic          dispatch_v;
  logic [PW-1:0] dispatch_pkt;
  logic [2:0]    pf_outstanding;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_be_prefetch_dispatch_arb #(
    .pkt_width_p(PW), .max_outstanding_p(4), .starve_limit_p(16), .holdoff_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset), .pf_enable_i(pf_enable), .flush_i(flush),
    .demand_v_i(demand_v), .demand_pkt_i(demand_pkt), .demand_yumi_o(demand_yumi),
    .pf_v_i(pf_v), .pf_pkt_i(pf_pkt), .pf_yumi_o(pf_yumi), .pf_done_i(pf_done),
    .dispatch_ready_and_i(ready), .dispatch_v_o(dispatch_v),
    .dispatch_pkt_o(dispatch_pkt), .pf_outstanding_o(pf_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, fl, dv, pv, done, rdy;
    logic e_dy, e_py, e_v;
    logic [PW-1:0] e_pkt;
    logic [2:0] e_out;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic fl, input logic dv,
                       input logic pv, input logic done, input logic rdy);
    reset = rst; pf_enable = en; flush = fl; demand_v = dv;
    pf_v = pv; pf_done = done; ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    int first_pf;
    // rst en fl dv pv done rdy | dy py v pkt out
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd1};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,DPKT,3'd2};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,PPKT,3'd2};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd2};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,DPKT,3'd2};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd2};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd3};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd4};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd4};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd3};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,DPKT,3'd4};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,DPKT,3'd4};
    vecs[15] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd3};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,PPKT,3'd0};
    vecs[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,16'h0000,3'd1};
    vecs[18] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,DPKT,3'd0};

    demand_pkt = DPKT;
    pf_pkt     = PPKT;
    do_reset();

    // Table: one vector per cycle, outputs checked mid-cycle.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].dv, vecs[i].pv, vecs[i].done, vecs[i].rdy);
      #4;
      chk("demand_yumi", i, 32'(demand_yumi), 32'(vecs[i].e_dy));
      chk("pf_yumi",     i, 32'(pf_yumi),     32'(vecs[i].e_py));
      chk("dispatch_v",  i, 32'(dispatch_v),  32'(vecs[i].e_v));
      if (vecs[i].e_v) chk("dispatch_pkt", i, 32'(dispatch_pkt), 32'(vecs[i].e_pkt));
      chk("outstanding", i, 32'(pf_outstanding), 32'(vecs[i].e_out));
      tick();
    end

    // Starvation: both valid every cycle -> 16 demand grants then one forced prefetch.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      #4;
      chk("starve_pf_yumi", i, 32'(pf_yumi), 32'((i % 17) == 16));
      chk("starve_dem_yumi", i, 32'(demand_yumi), 32'((i % 17) != 16));
      tick();
    end

    // Flush holdoff: no yumi on the flush cycle, no prefetch for 8 cycles, grant on the 9th.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #4;
    chk("flush_pf_yumi", 0, 32'(pf_yumi), 32'd0);
    chk("flush_dispatch_v", 0, 32'(dispatch_v), 32'd0);
    tick();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #4;
      chk("holdoff_pf_yumi", i, 32'(pf_yumi), 32'(i == 9));
      tick();
    end

    // Backpressure: ready low for 5 cycles with both valid; starvation keeps counting.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #4;
      chk("bp_dispatch_v", i, 32'(dispatch_v), 32'd1);
      chk("bp_pkt", i, 32'(dispatch_pkt), 32'(DPKT));
      chk("bp_yumis", i, 32'({demand_yumi, pf_yumi}), 32'd0);
      tick();
    end
    first_pf = -1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      #4;
      if (pf_yumi && first_pf < 0) first_pf = i;
      tick();
      if (first_pf >= 0) break;
    end
    chk("bp_first_pf_grant", 0, 32'(first_pf), 32'd11);

    // Reset mid-burst clears the outstanding count and blocks prefetch grants.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #4;
    chk("rst_pf_yumi", 0, 32'(pf_yumi), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #4;
    chk("rst_outstanding", 0, 32'(pf_outstanding), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
